minn_detect_ctrl: RTL
=====================

Name: minn_detect_ctrl

Overview:
Sequencing controller for the Minn timing-sync running-sum datapath.
- Flushes the metric and energy running sums on enable, so the adders start from zero.
- Arms a threshold comparison of metric against scaled energy.
- On a threshold crossing, runs a fixed-length peak search and reports the peak sample index, then holds off before re-arming.
- Sits between the running-sum instances and the frame-timing logic.

Parameters:
METRIC_WIDTH, 32, unsigned width of the metric running sum
ENERGY_WIDTH, 32, unsigned width of the energy running sum
INDEX_WIDTH, 16, width of the sample index counter (wraps modulo 2^INDEX_WIDTH)
SEARCH_LEN, 64, samples in the peak-search window including the trigger sample; must be >= 1
HOLDOFF_LEN, 256, samples ignored after a detection; must be >= 1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
enable  in  1  level; high runs the detector, low returns it to IDLE
in_valid  in  1  one-cycle strobe per new sum pair
sums_full  in  1  level from the running sums; high once their windows are filled
metric  in  METRIC_WIDTH  unsigned metric sum
energy  in  ENERGY_WIDTH  unsigned energy sum
thresh  in  8  Q0.8 threshold, sampled on every compare
sum_flush  out  1  drives the running-sum rst
detect_valid  out  1  one-cycle detection pulse
detect_index  out  INDEX_WIDTH  sample index of the peak
detect_metric  out  METRIC_WIDTH  peak metric value
state_out  out  3  current state encoding
busy  out  1  high when state is SEARCH or HOLDOFF

Behaviour:
- Reset values:
  - state is IDLE.
  - sum_flush=0, detect_valid=0, detect_index=0, detect_metric=0, busy=0.
  - All counters, peak and peak_idx registers are 0.
- State encoding: IDLE=0, FLUSH=1, ARMED=2, SEARCH=3, HOLDOFF=4, DONE=5. DONE is used only with the optional feature.
- A sample is "accepted" when in_valid && sums_full is true in ARMED, SEARCH or HOLDOFF. No other cycle is a sample.
- Sample index counter:
  - Cleared in FLUSH.
  - On each accepted sample, that sample's index is the current counter value; the counter then increments.
  - The first accepted sample after a flush has index 0. The counter wraps silently.
- Crossing test: metric != 0 and {metric,8'b0} >= energy*thresh.
  - Unsigned arithmetic at max(METRIC_WIDTH, ENERGY_WIDTH)+8 bits; no truncation.
  - thresh=0 means any nonzero metric crosses.
- IDLE:
  - enable=1 -> FLUSH.
  - in_valid is ignored.
- FLUSH:
  - sum_flush=1 for exactly one cycle.
  - Next state is ARMED, or IDLE if enable=0.
- ARMED: on an accepted sample that crosses:
  - peak<=metric, peak_idx<=index, search_cnt<=1, next state SEARCH.
  - If SEARCH_LEN==1, go directly to the detect path instead.
- SEARCH: on each accepted sample:
  - If metric > peak (strict), update peak and peak_idx; the earliest equal maximum wins.
  - search_cnt increments.
  - When the sample is the SEARCH_LEN-th, the next cycle asserts detect_valid=1 with detect_index=peak_idx and detect_metric=peak, including any update from that final sample.
  - State becomes HOLDOFF with holdoff_cnt=0.
- HOLDOFF:
  - Counts accepted samples.
  - After HOLDOFF_LEN samples, state becomes ARMED on the following cycle.
  - Samples seen during HOLDOFF are never compared.
- detect_index and detect_metric hold their value until the next detection or reset.
- enable=0 in any state except IDLE: next cycle is IDLE.
  - An in-progress search is discarded with no detect_valid.
  - A detect_valid already being driven this cycle still completes.
  - Re-enabling always goes through FLUSH.
- sums_full dropping mid-SEARCH: samples stop counting and the state is held, with no timeout.
- rst asserted mid-operation: reset values apply on the next edge; the search is abandoned.
- Latency: the crossing sample is seen at edge t and SEARCH is entered at t+1. detect_valid is asserted in the cycle after the edge that samples the SEARCH_LEN-th sample.

Optional Feature:
MINN_DETECT_ONESHOT_EN
- Defined: after a detection the controller enters DONE instead of HOLDOFF.
  - DONE keeps busy=0 and ignores samples.
  - It leaves only via enable=0 (to IDLE) or rst.
  - HOLDOFF_LEN is unused.
- Undefined: the free-running HOLDOFF -> ARMED cycle described above.

Test Plan:
- Reset, then enable=1 -> sum_flush high for exactly 1 cycle, state 1 then 2, all outputs 0.
- SEARCH_LEN=4, thresh=128, energy=100, metric sequence 10,60,70,90,80,50 at indices 0..5:
  - Crossing at index 1.
  - detect_valid fires one cycle after index 4 with detect_index=3, detect_metric=90.
- Tie case: metric 60,90,90,40 with SEARCH_LEN=4 -> detect_index is the first 90's index.
- Holdoff: HOLDOFF_LEN=8, crossings continuous -> second detect trigger no earlier than the 9th sample after the first window ends; busy high throughout.
- enable drops 2 samples into SEARCH -> no detect_valid; IDLE next cycle; re-enable gives a new sum_flush pulse and the index restarts at 0.
- sums_full=0 with in_valid pulses in ARMED -> no state change. With MINN_DETECT_ONESHOT_EN: after the first detect, state 5 persists despite further crossings until enable=0.

Source files
------------

// File: rtl/minn_detect_if.sv
// Handshake/bus bundle between the Minn running-sum datapath, the detect controller and frame timing.
// The master side drives the sample stream and config; the slave side is the controller.
interface minn_detect_if #(
  parameter int METRIC_WIDTH = 32,
  parameter int ENERGY_WIDTH = 32,
  parameter int INDEX_WIDTH  = 16
);
  logic                    enable;
  logic                    in_valid;
  logic                    sums_full;
  logic [METRIC_WIDTH-1:0] metric;
  logic [ENERGY_WIDTH-1:0] energy;
  logic [7:0]              thresh;
  logic                    sum_flush;
  logic                    detect_valid;
  logic [INDEX_WIDTH-1:0]  detect_index;
  logic [METRIC_WIDTH-1:0] detect_metric;
  logic [2:0]              state_out;
  logic                    busy;

  modport master (
    output enable, in_valid, sums_full, metric, energy, thresh,
    input  sum_flush, detect_valid, detect_index, detect_metric, state_out, busy
  );

  modport slave (
    input  enable, in_valid, sums_full, metric, energy, thresh,
    output sum_flush, detect_valid, detect_index, detect_metric, state_out, busy
  );
endinterface

// File: rtl/minn_detect_ctrl.sv
// Minn timing-sync detect controller: flush, threshold arm, fixed-window peak search, holdoff.
// Optional MINN_DETECT_ONESHOT_EN: park in DONE after the first detection instead of HOLDOFF.
module minn_detect_ctrl #(
  parameter int METRIC_WIDTH = 32,
  parameter int ENERGY_WIDTH = 32,
  parameter int INDEX_WIDTH  = 16,
  parameter int SEARCH_LEN   = 64,
  parameter int HOLDOFF_LEN  = 256
) (
  input  logic          clk,
  input  logic          rst,
  minn_detect_if.slave  bus
);

  localparam int CMP_W  = ((METRIC_WIDTH > ENERGY_WIDTH) ? METRIC_WIDTH : ENERGY_WIDTH) + 8;
  localparam int SCNT_W = $clog2(SEARCH_LEN + 1);
  localparam int HCNT_W = $clog2(HOLDOFF_LEN + 1);
  localparam logic [SCNT_W-1:0] SEARCH_LAST  = SCNT_W'(SEARCH_LEN - 1);
  localparam logic [HCNT_W-1:0] HOLDOFF_LAST = HCNT_W'(HOLDOFF_LEN - 1);
  localparam bit SINGLE = (SEARCH_LEN == 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FLUSH   = 3'd1,
    S_ARMED   = 3'd2,
    S_SEARCH  = 3'd3,
    S_HOLDOFF = 3'd4,
    S_DONE    = 3'd5
  } state_t;

`ifdef MINN_DETECT_ONESHOT_EN
  localparam state_t S_AFTER = S_DONE;
`else
  localparam state_t S_AFTER = S_HOLDOFF;
`endif

  // Full-width compare: metric*256 against energy*thresh, no bits dropped.
  function automatic logic f_crosses(input logic [METRIC_WIDTH-1:0] m,
                                     input logic [ENERGY_WIDTH-1:0] e,
                                     input logic [7:0]              t);
    logic [CMP_W-1:0] lhs;
    logic [CMP_W-1:0] rhs;
    lhs = CMP_W'(m) << 8;
    rhs = CMP_W'(e) * CMP_W'(t);
    return (m != '0) && (lhs >= rhs);
  endfunction

  state_t                  r_state;
  state_t                  w_next;
  logic [INDEX_WIDTH-1:0]  r_idx;
  logic [INDEX_WIDTH-1:0]  r_peak_idx;
  logic [INDEX_WIDTH-1:0]  r_det_idx;
  logic [METRIC_WIDTH-1:0] r_peak;
  logic [METRIC_WIDTH-1:0] r_det_metric;
  logic [SCNT_W-1:0]       r_search_cnt;
  logic [HCNT_W-1:0]       r_hold_cnt;
  logic                    r_det_valid;

  logic                    w_accept;
  logic                    w_cross;
  logic                    w_better;
  logic                    w_detect;
  logic [METRIC_WIDTH-1:0] w_fin_peak;
  logic [INDEX_WIDTH-1:0]  w_fin_idx;

  assign w_accept = bus.in_valid && bus.sums_full &&
                    ((r_state == S_ARMED) || (r_state == S_SEARCH) || (r_state == S_HOLDOFF));
  assign w_cross  = f_crosses(bus.metric, bus.energy, bus.thresh);
  assign w_better = (bus.metric > r_peak);

  // Detection is registered on the edge that takes the last window sample.
  always_comb begin
    w_detect   = 1'b0;
    w_fin_peak = r_peak;
    w_fin_idx  = r_peak_idx;
    if (bus.enable && w_accept) begin
      if (r_state == S_ARMED && w_cross && SINGLE) begin
        w_detect   = 1'b1;
        w_fin_peak = bus.metric;
        w_fin_idx  = r_idx;
      end else if (r_state == S_SEARCH && r_search_cnt == SEARCH_LAST) begin
        w_detect = 1'b1;
        if (w_better) begin
          w_fin_peak = bus.metric;
          w_fin_idx  = r_idx;
        end
      end
    end
  end

  always_comb begin
    w_next = r_state;
    if (!bus.enable) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    w_next = S_FLUSH;
        S_FLUSH:   w_next = S_ARMED;
        S_ARMED:   if (w_accept && w_cross) w_next = SINGLE ? S_AFTER : S_SEARCH;
        S_SEARCH:  if (w_accept && r_search_cnt == SEARCH_LAST) w_next = S_AFTER;
        S_HOLDOFF: if (w_accept && r_hold_cnt == HOLDOFF_LAST) w_next = S_ARMED;
        S_DONE:    w_next = S_DONE;
        default:   w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx        <= '0;
      r_peak_idx   <= '0;
      r_peak       <= '0;
      r_search_cnt <= '0;
      r_hold_cnt   <= '0;
      r_det_valid  <= 1'b0;
      r_det_idx    <= '0;
      r_det_metric <= '0;
    end else begin
      r_det_valid <= w_detect;
      if (w_detect) begin
        r_det_idx    <= w_fin_idx;
        r_det_metric <= w_fin_peak;
      end
      if (r_state == S_FLUSH)  r_idx <= '0;
      else if (w_accept)       r_idx <= r_idx + 1'b1;
      case (r_state)
        S_ARMED: if (w_accept && w_cross) begin
          r_peak       <= bus.metric;
          r_peak_idx   <= r_idx;
          r_search_cnt <= SCNT_W'(1);
          r_hold_cnt   <= '0;
        end
        S_SEARCH: if (w_accept) begin
          if (w_better) begin
            r_peak     <= bus.metric;
            r_peak_idx <= r_idx;
          end
          r_search_cnt <= r_search_cnt + 1'b1;
          r_hold_cnt   <= '0;
        end
        S_HOLDOFF: if (w_accept) r_hold_cnt <= r_hold_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.sum_flush     = (r_state == S_FLUSH);
  assign bus.busy          = (r_state == S_SEARCH) || (r_state == S_HOLDOFF);
  assign bus.state_out     = r_state;
  assign bus.detect_valid  = r_det_valid;
  assign bus.detect_index  = r_det_idx;
  assign bus.detect_metric = r_det_metric;

endmodule
